// File: rtl/l2_cache_pkg.sv
// Shared types and helpers for the write-back L2 cache.
package l2_cache_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StWriteback,
        StRefill,
        StRespond,
        StFlushScan,
        StFlushWb
    } l2_state_e;

    localparam int unsigned REPL_RANDOM = 0;
    localparam int unsigned REPL_RR     = 1;

    function automatic int unsigned offset_width(input int unsigned block_size);
        return $clog2(block_size);
    endfunction

    function automatic int unsigned index_width(input int unsigned cache_size,
                                                input int unsigned block_size,
                                                input int unsigned num_ways);
        return $clog2(cache_size / block_size / num_ways);
    endfunction

    function automatic int unsigned tag_width(input int unsigned addr_width,
                                              input int unsigned cache_size,
                                              input int unsigned block_size,
                                              input int unsigned num_ways);
        return addr_width - offset_width(block_size)
               - index_width(cache_size, block_size, num_ways);
    endfunction

endpackage

// File: rtl/l2_victim_sel.sv
// Combinational victim-way selection: lowest invalid way first, then random or round-robin.
module l2_victim_sel
    import l2_cache_pkg::*;
#(
    parameter int unsigned NUM_WAYS  = 4,
    parameter int unsigned REPL_MODE = REPL_RANDOM,
    localparam int unsigned WayW     = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0] way_valid,
    input  logic [WayW-1:0]     rand_way,
    input  logic [WayW-1:0]     rr_ptr,
    output logic [WayW-1:0]     victim,
    output logic                all_valid
);

    // Scan downwards so the lowest-numbered invalid way wins
    always_comb begin
        all_valid = &way_valid;
        victim    = (REPL_MODE == REPL_RR) ? rr_ptr : rand_way;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) victim = WayW'(w);
        end
    end

endmodule

// File: rtl/l2_cache_wb.sv
// Set-associative write-back, write-allocate L2 cache with whole-cache flush.
module l2_cache_wb
    import l2_cache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned CACHE_SIZE    = 1024,
    parameter int unsigned BLOCK_SIZE    = 16,
    parameter int unsigned NUM_WAYS      = 4,
    parameter int unsigned L1_BLOCK_SIZE = 4,
    parameter int unsigned HIT_LATENCY   = 4,
    parameter int unsigned REPL_MODE     = REPL_RANDOM
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [ADDR_WIDTH-1:0]                        l2_cache_addr,
    input  logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]     l2_cache_data_in,
    input  logic                                         l2_cache_read,
    input  logic                                         l2_cache_write,
    output logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]     l2_cache_data_out,
    output logic                                         l2_cache_ready,
    output logic                                         l2_hit,
    input  logic                                         l2_flush,
    output logic                                         l2_flush_done,
    output logic [ADDR_WIDTH-1:0]                        mem_addr,
    output logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]        mem_data_out,
    input  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]        mem_data_in,
    output logic                                         mem_read,
    output logic                                         mem_write,
    input  logic                                         mem_ready,
    input  logic [$clog2(NUM_WAYS)-1:0]                  rand_way
);

    localparam int unsigned NumSets  = CACHE_SIZE / BLOCK_SIZE / NUM_WAYS;
    localparam int unsigned NumLines = NumSets * NUM_WAYS;
    localparam int unsigned OffW     = offset_width(BLOCK_SIZE);
    localparam int unsigned IdxW     = index_width(CACHE_SIZE, BLOCK_SIZE, NUM_WAYS);
    localparam int unsigned TagW     = tag_width(ADDR_WIDTH, CACHE_SIZE, BLOCK_SIZE, NUM_WAYS);
    localparam int unsigned WayW     = $clog2(NUM_WAYS);
    localparam int unsigned LineW    = IdxW + WayW;
    localparam int unsigned LatW     = $clog2(HIT_LATENCY + 1);

    typedef logic [L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0] sub_t;
    typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0]    line_t;

    line_t               data_q [NumLines];
    logic [TagW-1:0]     tag_q  [NumLines];
    logic [NumLines-1:0] valid_q, dirty_q;
    logic [WayW-1:0]     rr_q   [NumSets];

    l2_state_e              state_q;
    logic [LatW-1:0]        lat_cnt_q;
    logic [ADDR_WIDTH-1:0]  req_addr_q;
    sub_t                   req_wdata_q;
    logic                   req_write_q;
    logic [WayW-1:0]        victim_q;
    logic [LineW-1:0]       flush_idx_q;
    sub_t                   data_out_q;
    logic                   hit_q, flush_done_q;

    logic [TagW-1:0]     req_tag;
    logic [IdxW-1:0]     req_idx;
    logic [OffW-1:0]     req_start;
    logic [NUM_WAYS-1:0] set_valid;
    logic                hit, all_valid, resolve, wr_hit_en, refill_en;
    logic [WayW-1:0]     hit_way, sel_victim;
    logic [LineW-1:0]    hit_line, sel_line, victim_line;

    function automatic sub_t get_sub(input line_t line, input logic [OffW-1:0] start);
        sub_t s;
        for (int i = 0; i < L1_BLOCK_SIZE; i++) s[i] = line[start + OffW'(i)];
        return s;
    endfunction

    function automatic line_t merge(input line_t line, input logic [OffW-1:0] start,
                                    input sub_t wdata);
        line_t l;
        l = line;
        for (int i = 0; i < L1_BLOCK_SIZE; i++) l[start + OffW'(i)] = wdata[i];
        return l;
    endfunction

    assign req_tag     = req_addr_q[ADDR_WIDTH-1 -: TagW];
    assign req_idx     = req_addr_q[OffW +: IdxW];
    assign req_start   = req_addr_q[OffW-1:0] & ~OffW'(L1_BLOCK_SIZE - 1);
    assign hit_line    = {req_idx, hit_way};
    assign sel_line    = {req_idx, sel_victim};
    assign victim_line = {req_idx, victim_q};
    assign resolve     = (state_q == StLookup) && (lat_cnt_q == LatW'(HIT_LATENCY - 1));
    assign wr_hit_en   = resolve && hit && req_write_q;
    assign refill_en   = (state_q == StRefill) && mem_ready && !rst;

    // Tag compare across the ways of the requested set
    always_comb begin
        set_valid = '0;
        hit       = 1'b0;
        hit_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            set_valid[w] = valid_q[{req_idx, WayW'(w)}];
            if (set_valid[w] && tag_q[{req_idx, WayW'(w)}] == req_tag) begin
                hit     = 1'b1;
                hit_way = WayW'(w);
            end
        end
    end

    l2_victim_sel #(
        .NUM_WAYS  (NUM_WAYS),
        .REPL_MODE (REPL_MODE)
    ) u_victim_sel (
        .way_valid (set_valid),
        .rand_way  (rand_way),
        .rr_ptr    (rr_q[req_idx]),
        .victim    (sel_victim),
        .all_valid (all_valid)
    );

    // Line storage: write-hit merge and refill install; validity lives in valid_q
    always_ff @(posedge clk) begin
        if (wr_hit_en) data_q[hit_line] <= merge(data_q[hit_line], req_start, req_wdata_q);
        if (refill_en) begin
            data_q[victim_line] <= req_write_q ? merge(mem_data_in, req_start, req_wdata_q)
                                               : mem_data_in;
            tag_q[victim_line]  <= req_tag;
        end
    end

    // Control FSM, line status bits and registered responses
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            lat_cnt_q    <= '0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_write_q  <= 1'b0;
            victim_q     <= '0;
            flush_idx_q  <= '0;
            data_out_q   <= '0;
            hit_q        <= 1'b0;
            flush_done_q <= 1'b0;
            valid_q      <= '0;
            dirty_q      <= '0;
            for (int s = 0; s < NumSets; s++) rr_q[s] <= '0;
        end else begin
            flush_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    lat_cnt_q <= '0;
                    if (l2_flush) begin
                        flush_idx_q <= '0;
                        state_q     <= StFlushScan;
                    end else if (l2_cache_read || l2_cache_write) begin
                        req_addr_q  <= l2_cache_addr;
                        req_wdata_q <= l2_cache_data_in;
                        req_write_q <= l2_cache_write;
                        state_q     <= StLookup;
                    end
                end
                StLookup: begin
                    if (!resolve) begin
                        lat_cnt_q <= lat_cnt_q + 1'b1;
                    end else if (hit) begin
                        hit_q   <= 1'b1;
                        state_q <= StRespond;
                        if (req_write_q) begin
                            dirty_q[hit_line] <= 1'b1;
                            data_out_q        <= req_wdata_q;
                        end else begin
                            data_out_q <= get_sub(data_q[hit_line], req_start);
                        end
                    end else begin
                        hit_q    <= 1'b0;
                        victim_q <= sel_victim;
                        // Pointer only advances when a valid line is actually displaced
                        if (all_valid) rr_q[req_idx] <= rr_q[req_idx] + 1'b1;
                        state_q  <= (valid_q[sel_line] && dirty_q[sel_line]) ? StWriteback
                                                                             : StRefill;
                    end
                end
                StWriteback: if (mem_ready) state_q <= StRefill;
                StRefill: begin
                    if (mem_ready) begin
                        valid_q[victim_line] <= 1'b1;
                        dirty_q[victim_line] <= req_write_q;
                        data_out_q <= req_write_q ? req_wdata_q : get_sub(mem_data_in, req_start);
                        state_q    <= StRespond;
                    end
                end
                StRespond: state_q <= StIdle;
                StFlushScan: begin
                    if (valid_q[flush_idx_q] && dirty_q[flush_idx_q]) begin
                        state_q <= StFlushWb;
                    end else if (flush_idx_q == LineW'(NumLines - 1)) begin
                        flush_done_q <= 1'b1;
                        state_q      <= StIdle;
                    end else begin
                        flush_idx_q <= flush_idx_q + 1'b1;
                    end
                end
                StFlushWb: begin
                    if (mem_ready) begin
                        dirty_q[flush_idx_q] <= 1'b0;
                        if (flush_idx_q == LineW'(NumLines - 1)) begin
                            flush_done_q <= 1'b1;
                            state_q      <= StIdle;
                        end else begin
                            flush_idx_q <= flush_idx_q + 1'b1;
                            state_q     <= StFlushScan;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Memory strobes and address/data follow the state directly
    always_comb begin
        mem_read     = (state_q == StRefill);
        mem_write    = (state_q == StWriteback) || (state_q == StFlushWb);
        mem_addr     = '0;
        mem_data_out = '0;
        case (state_q)
            StWriteback: begin
                mem_addr     = {tag_q[victim_line], req_idx, OffW'(0)};
                mem_data_out = data_q[victim_line];
            end
            StRefill: mem_addr = {req_tag, req_idx, OffW'(0)};
            StFlushWb: begin
                mem_addr     = {tag_q[flush_idx_q], flush_idx_q[LineW-1:WayW], OffW'(0)};
                mem_data_out = data_q[flush_idx_q];
            end
            default: ;
        endcase
    end

    assign l2_cache_data_out = data_out_q;
    assign l2_cache_ready    = (state_q == StRespond);
    assign l2_hit            = hit_q;
    assign l2_flush_done     = flush_done_q;

endmodule

// File: tb/tb_l2_cache_wb.sv
// Scoreboard bench for l2_cache_wb: random-mode instance plus a round-robin instance.
module tb_l2_cache_wb;

    typedef logic [3:0][31:0]  blk_t;
    typedef logic [15:0][31:0] line_t;
    typedef struct { blk_t data; logic hit; } rsp_t;
    typedef struct { bit wr; logic [31:0] addr; line_t wline; line_t fill; } mop_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] l2_addr;
    blk_t        l2_din;
    logic        l2_rd, l2_wr, l2_flush;
    line_t       mem_din;
    logic        mem_rdy;
    logic [1:0]  rand_way;
    bit          sel;
    int          cyc = 0;

    blk_t a_dout, b_dout, s_dout;
    logic a_ready, a_hit, a_fdone, a_mrd, a_mwr;
    logic b_ready, b_hit, b_fdone, b_mrd, b_mwr;
    logic s_ready, s_hit, s_fdone, s_mrd, s_mwr;
    logic [31:0] a_maddr, b_maddr, s_maddr;
    line_t a_mdout, b_mdout, s_mdout;

    l2_cache_wb #(.REPL_MODE(0)) dut (
        .clk(clk), .rst(rst), .l2_cache_addr(l2_addr), .l2_cache_data_in(l2_din),
        .l2_cache_read(l2_rd), .l2_cache_write(l2_wr), .l2_cache_data_out(a_dout),
        .l2_cache_ready(a_ready), .l2_hit(a_hit), .l2_flush(l2_flush),
        .l2_flush_done(a_fdone), .mem_addr(a_maddr), .mem_data_out(a_mdout),
        .mem_data_in(mem_din), .mem_read(a_mrd), .mem_write(a_mwr), .mem_ready(mem_rdy),
        .rand_way(rand_way)
    );

    l2_cache_wb #(.REPL_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .l2_cache_addr(l2_addr), .l2_cache_data_in(l2_din),
        .l2_cache_read(l2_rd), .l2_cache_write(l2_wr), .l2_cache_data_out(b_dout),
        .l2_cache_ready(b_ready), .l2_hit(b_hit), .l2_flush(l2_flush),
        .l2_flush_done(b_fdone), .mem_addr(b_maddr), .mem_data_out(b_mdout),
        .mem_data_in(mem_din), .mem_read(b_mrd), .mem_write(b_mwr), .mem_ready(mem_rdy),
        .rand_way(rand_way)
    );

    assign s_dout  = sel ? b_dout  : a_dout;
    assign s_ready = sel ? b_ready : a_ready;
    assign s_hit   = sel ? b_hit   : a_hit;
    assign s_fdone = sel ? b_fdone : a_fdone;
    assign s_mrd   = sel ? b_mrd   : a_mrd;
    assign s_mwr   = sel ? b_mwr   : a_mwr;
    assign s_maddr = sel ? b_maddr : a_maddr;
    assign s_mdout = sel ? b_mdout : a_mdout;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic line_t mkline(input logic [31:0] base, input logic [31:0] step);
        line_t l;
        for (int k = 0; k < 16; k++) l[k] = base + step * 32'(k);
        return l;
    endfunction

    function automatic blk_t sub(input line_t l, input int s);
        blk_t b;
        for (int i = 0; i < 4; i++) b[i] = l[s + i];
        return b;
    endfunction

    // Response scoreboard
    rsp_t sb_q[$];
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (s_ready) begin
                if (sb_q.size() == 0) check_eq("rsp_unexpected", 1, 0);
                else begin
                    e = sb_q.pop_front();
                    check_eq("rsp_data", s_dout, e.data);
                    check_eq("rsp_hit", s_hit, e.hit);
                end
            end
        end
    end

    // Memory model: answers each strobe on its third cycle from the expected-op queue
    mop_t mq[$];
    bit   mem_hold = 0;
    int   mcnt = 0, n_mwr = 0, n_mrd = 0, strobe_cyc = 0;
    initial begin
        mop_t e;
        mem_rdy = 1'b0;
        mem_din = '0;
        forever begin
            @(negedge clk);
            if (mem_rdy || rst || mem_hold) begin
                mem_rdy = 1'b0;
                mcnt    = 0;
            end else if (s_mrd || s_mwr) begin
                mcnt++;
                if (mcnt == 1) strobe_cyc = cyc;
                if (mcnt == 3) begin
                    check_eq("mem_excl", s_mrd & s_mwr, 0);
                    if (s_mwr) n_mwr++; else n_mrd++;
                    if (mq.size() == 0) begin
                        check_eq("mem_unexpected", 1, 0);
                        mem_din = '0;
                    end else begin
                        e = mq.pop_front();
                        check_eq("mem_op_wr", s_mwr, e.wr);
                        check_eq("mem_addr", s_maddr, e.addr);
                        if (e.wr) check_eq("mem_wline", s_mdout, e.wline);
                        mem_din = e.fill;
                    end
                    mem_rdy = 1'b1;
                end
            end
        end
    end

    task automatic push_mop(input bit wr, input logic [31:0] a, input line_t wl, input line_t fl);
        mop_t m;
        m.wr = wr; m.addr = a; m.wline = wl; m.fill = fl;
        mq.push_back(m);
    endtask

    int req_cyc;
    task automatic do_req(input bit w, input logic [31:0] a, input blk_t d, input blk_t ed,
                          input logic eh, output int lat);
        rsp_t r;
        @(negedge clk);
        r.data = ed; r.hit = eh;
        sb_q.push_back(r);
        l2_addr = a; l2_din = d; l2_wr = w; l2_rd = !w;
        req_cyc = cyc;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!s_ready && lat < 300);
        if (!s_ready) check_eq("req_timeout", 0, 1);
        l2_rd = 1'b0; l2_wr = 1'b0;
    endtask

    task automatic do_flush(output int n);
        @(negedge clk);
        l2_flush = 1'b1;
        n = 0;
        do begin @(negedge clk); l2_flush = 1'b0; n++; end while (!s_fdone && n < 500);
        check_eq("flush_done_seen", s_fdone, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int    lat, m0, w0, fc, waitn;
        line_t line0, l140, l80, lf, l900;
        blk_t  aa, d14, d58, zero;
        rst = 1'b1; l2_rd = 1'b0; l2_wr = 1'b0; l2_flush = 1'b0;
        l2_addr = '0; l2_din = '0; rand_way = 2'd0; sel = 1'b0;
        zero = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", s_ready, 0);
        check_eq("rst_mem_read", s_mrd, 0);
        check_eq("rst_mem_write", s_mwr, 0);
        check_eq("rst_data_out", s_dout, 0);
        check_eq("rst_hit", s_hit, 0);
        check_eq("rst_flush_done", s_fdone, 0);
        rst = 1'b0;

        // Cold read miss, then sub-block hit on the same line
        line0 = mkline(32'h100, 1);
        push_mop(0, 32'h40, '0, line0);
        do_req(0, 32'h40, zero, sub(line0, 0), 0, lat);
        check_eq("miss_strobe_delay", strobe_cyc - req_cyc, 5);
        m0 = n_mrd + n_mwr;
        do_req(0, 32'h44, zero, sub(line0, 4), 1, lat);
        check_eq("hit_latency", lat, 5);
        check_eq("hit_no_mem", n_mrd + n_mwr, m0);

        // Write hit, fill set 4, then dirty eviction of way 0
        aa = {4{32'hAAAA_AAAA}};
        do_req(1, 32'h48, aa, aa, 1, lat);
        check_eq("wr_hit_no_mem", n_mrd + n_mwr, m0);
        for (int i = 8; i < 12; i++) line0[i] = 32'hAAAA_AAAA;
        l140 = mkline(32'h1140, 1);
        push_mop(0, 32'h140, '0, l140);
        do_req(0, 32'h140, zero, sub(l140, 0), 0, lat);
        for (int t = 2; t < 4; t++) begin
            lf = mkline(32'h1040 + 32'(t) * 32'h100, 1);
            push_mop(0, 32'h40 + 32'(t) * 32'h100, '0, lf);
            do_req(0, 32'h40 + 32'(t) * 32'h100, zero, sub(lf, 0), 0, lat);
        end
        rand_way = 2'd0;
        lf = mkline(32'h2440, 1);
        push_mop(1, 32'h40, line0, '0);
        push_mop(0, 32'h440, '0, lf);
        do_req(0, 32'h440, zero, sub(lf, 0), 0, lat);

        // Write-allocate miss with zero refill
        d14 = {32'd4, 32'd3, 32'd2, 32'd1};
        l80 = mkline(32'h0, 0);
        push_mop(0, 32'h80, '0, l80);
        do_req(1, 32'h84, d14, d14, 0, lat);
        for (int i = 0; i < 4; i++) l80[4 + i] = 32'(i + 1);
        do_req(0, 32'h80, zero, zero, 1, lat);
        do_req(0, 32'h84, zero, d14, 1, lat);

        // Flush with two dirty lines, then a clean flush
        d58 = {32'd8, 32'd7, 32'd6, 32'd5};
        do_req(1, 32'h140, d58, d58, 1, lat);
        for (int i = 0; i < 4; i++) l140[i] = 32'(i + 5);
        push_mop(1, 32'h140, l140, '0);
        push_mop(1, 32'h80, l80, '0);
        w0 = n_mwr;
        do_flush(fc);
        check_eq("flush1_writes", n_mwr - w0, 2);
        check_eq("flush1_queue", mq.size(), 0);
        w0 = n_mwr;
        do_flush(fc);
        check_eq("flush2_cycles", fc, 65);
        check_eq("flush2_writes", n_mwr - w0, 0);
        do_req(0, 32'h84, zero, d14, 1, lat);

        // Reset while the refill is outstanding
        mem_hold = 1;
        @(negedge clk);
        l2_addr = 32'h900; l2_rd = 1'b1;
        waitn = 0;
        while (!s_mrd && waitn < 50) begin @(negedge clk); waitn++; end
        check_eq("rst_refill_reached", s_mrd, 1);
        rst = 1'b1; l2_rd = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_mem_read", s_mrd, 0);
        check_eq("rst_mid_ready", s_ready, 0);
        rst = 1'b0;
        mem_hold = 0;
        l900 = mkline(32'h3900, 1);
        push_mop(0, 32'h900, '0, l900);
        do_req(0, 32'h900, zero, sub(l900, 0), 0, lat);

        // Round-robin instance: fill set 0, five evictions must hit ways 0,1,2,3,0
        sel = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rand_way = 2'd3;
        for (int t = 0; t < 9; t++) begin
            lf = mkline(32'h5000 + 32'(t) * 32'h100, 1);
            push_mop(0, 32'(t) * 32'h100, '0, lf);
            do_req(0, 32'(t) * 32'h100, zero, sub(lf, 0), 0, lat);
        end
        m0 = n_mrd + n_mwr;
        for (int t = 5; t < 9; t++) begin
            lf = mkline(32'h5000 + 32'(t) * 32'h100, 1);
            do_req(0, 32'(t) * 32'h100, zero, sub(lf, 0), 1, lat);
        end
        check_eq("rr_survivors_no_mem", n_mrd + n_mwr, m0);
        lf = mkline(32'h6400, 1);
        push_mop(0, 32'h400, '0, lf);
        do_req(0, 32'h400, zero, sub(lf, 0), 0, lat);

        repeat (2) @(negedge clk);
        check_eq("sb_drained", sb_q.size(), 0);
        check_eq("mem_drained", mq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/l2_cache_wb.md
# l2_cache_wb

Parametrised set-associative L2 cache with write-back and write-allocate. It sits between the L1 cache and main memory and supersedes the read-only L2: it adds write hits, dirty tracking and victim write-back. It also adds a selectable replacement mode, a configurable hit latency and a whole-cache flush. Addresses are word addresses; L1 transfers are sub-blocks of `L1_BLOCK_SIZE` words; memory transfers are whole lines.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width.
- `ADDR_WIDTH`, 32: word-address width.
- `CACHE_SIZE`, 1024: capacity in words.
- `BLOCK_SIZE`, 16: line size in words; power of 2.
- `NUM_WAYS`, 4: associativity; power of 2, ≥2.
- `L1_BLOCK_SIZE`, 4: L1 sub-block in words; power of 2, ≤ `BLOCK_SIZE`.
- `HIT_LATENCY`, 4: lookup cycles, ≥1.
- `REPL_MODE`, 0: 0 = random (`rand_way`), 1 = per-set round-robin.

Ports (clock and reset first):
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `l2_cache_addr` in `ADDR_WIDTH`: request word address.
- `l2_cache_data_in` in `[L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]`: write sub-block.
- `l2_cache_read` / `l2_cache_write` in 1: request strobes.
- `l2_cache_data_out` out `[L1_BLOCK_SIZE-1:0][DATA_WIDTH-1:0]`: read sub-block.
- `l2_cache_ready` out 1: one-cycle completion pulse.
- `l2_hit` out 1: registered; qualified by `l2_cache_ready`.
- `l2_flush` in 1: request write-back of all dirty lines.
- `l2_flush_done` out 1: one-cycle pulse at flush end.
- `mem_addr` out `ADDR_WIDTH`: line base address.
- `mem_data_out` out `[BLOCK_SIZE-1:0][DATA_WIDTH-1:0]`: victim line.
- `mem_data_in` in `[BLOCK_SIZE-1:0][DATA_WIDTH-1:0]`: refill line.
- `mem_read` / `mem_write` out 1: memory strobes.
- `mem_ready` in 1: memory completion, one-cycle pulse.
- `rand_way` in `$clog2(NUM_WAYS)`: random victim way (mode 0).

## Operation
- Address fields: offset = `[log2(BLOCK_SIZE)-1:0]`; index next `log2(NUM_SETS)` bits, where `NUM_SETS = CACHE_SIZE/BLOCK_SIZE/NUM_WAYS`; tag is the remainder.
- Sub-block start = offset with its low `log2(L1_BLOCK_SIZE)` bits cleared.
- Per line the cache keeps tag, data, valid and dirty. Per set it keeps a round-robin pointer (`log2(NUM_WAYS)` bits, wraps).
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND, FLUSH_SCAN, FLUSH_WB.
- IDLE:
  - `l2_flush` has priority and goes to FLUSH_SCAN.
  - Otherwise read or write latches address, data and op, then goes to LOOKUP. If both strobes are high, the request is a write.
- LOOKUP holds `HIT_LATENCY` cycles, then resolves:
  - Write hit: merge the sub-block and set dirty.
  - Any hit: go to RESPOND.
  - Miss: choose a victim, then go to WRITEBACK if the victim is valid and dirty, else REFILL.
- Victim selection:
  - The lowest-numbered invalid way is taken first.
  - Otherwise mode 0 uses `rand_way`, sampled in the last LOOKUP cycle.
  - Otherwise mode 1 uses the set pointer, which increments after each eviction.
- WRITEBACK: `mem_write`=1, `mem_addr` = {victim tag, index, 0}, `mem_data_out` = victim line. On `mem_ready`, go to REFILL.
- REFILL: `mem_read`=1, `mem_addr` = {tag, index, 0}. On `mem_ready`:
  - Install `mem_data_in`, set valid.
  - For a write, merge the write sub-block and set dirty=1; for a read, dirty=0.
  - Go to RESPOND.
- RESPOND: `l2_cache_ready`=1 for exactly one cycle, with `l2_hit` valid.
  - For reads, `l2_cache_data_out` = line words [start .. start+L1_BLOCK_SIZE-1]. For writes it holds the merged sub-block.
  - The values hold until the next RESPOND. Then go to IDLE.
- FLUSH_SCAN visits lines 0..NUM_SETS*NUM_WAYS-1, one per cycle:
  - A valid and dirty line goes to FLUSH_WB, which writes it back like WRITEBACK, clears dirty (valid stays set) and resumes at the next line.
  - After the last line: `l2_flush_done` pulse, then IDLE.
- Reset clears all valid and dirty bits, the round-robin pointers, every output (data outputs to 0) and the state (to IDLE).

## Timing
- A hit read issued in cycle 0 gets `l2_cache_ready` in cycle `HIT_LATENCY`+1 with no memory activity.
- Miss: `mem_read` or `mem_write` rises in the cycle after the last LOOKUP cycle.
- Memory handshake:
  - `mem_read` and `mem_write` are never high together.
  - Each strobe holds until `mem_ready` is sampled and falls in the following cycle.
  - `mem_ready` is ignored while no strobe is active.
  - WRITEBACK's `mem_write` falls and REFILL's `mem_read` rises in the same cycle.
- Requesters hold their strobes until `l2_cache_ready`. Strobes still high in the IDLE cycle after RESPOND count as a new request.
- `l2_flush` is sampled only in IDLE. A flush that finds no dirty lines takes `NUM_SETS*NUM_WAYS`+1 cycles to `l2_flush_done`.
- Reset mid-transaction: the FSM is in IDLE and every strobe is 0 after the reset edge. A partially refilled line is left invalid. Memory must tolerate the abandoned request.

## Structure
- Package `l2_cache_pkg` holds:
  - the state enum;
  - `REPL_RANDOM`=0 and `REPL_RR`=1;
  - the field-width helper functions.
- Sub-module `l2_victim_sel` provides combinational way selection: invalid-first, then random or round-robin.

## Test plan
Default parameters unless noted; 16 sets, so index = `addr[7:4]`.
- Cold read of 0x40, memory returns word k = 0x100+k:
  - Expect `mem_read` with `mem_addr`=0x40, then `l2_cache_data_out`=0x100..0x103 and `l2_hit`=0.
  - A following read of 0x44 gets ready exactly 5 cycles after the request, data 0x104..0x107, `l2_hit`=1, no memory strobe.
- Write 0xAAAA_AAAA×4 to 0x48 (hit); fill set 4 with 0x140, 0x240 and 0x340; then read 0x440 with `rand_way`=0:
  - Expect `mem_write` to 0x40 with words 8..11 = 0xAAAA_AAAA, then `mem_read` to 0x440.
- Write miss to 0x84 with data 1,2,3,4, refill words 0:
  - Expect a later read of 0x80 to return 0,0,0,0 and a read of 0x84 to return 1,2,3,4.
- `REPL_MODE`=1, set 0 full and clean:
  - Five misses to distinct tags must evict ways 0,1,2,3,0 in that order.
- Two dirty lines, then `l2_flush`:
  - Expect exactly two `mem_write`s, then `l2_flush_done`.
  - A second flush makes zero writes and finishes in 65 cycles.
- `rst` asserted during REFILL:
  - `mem_read`=0 after the reset edge.
  - Re-reading the same address misses again.
